loop_station: RTL and testbench
===============================

// Module: loop_station
// PURPOSE
//  Last stage of the effect chain: a single-track looper. Takes the delay-stage sample,
//  records it to the SRAM loop region, plays it back mixed with live input, and drives the DAC word.
//  Owns the SRAM port from the cycle after i_valid until its own o_valid; then the port returns to idle.
// PARAMETERS
//  LOOP_BASE   20'h80000  first SRAM word of loop region (delay uses the lower half)
//  MAX_LEN     20'h7FFFF  maximum loop length in samples; reaching it ends recording
// PORTS
//  i_AUD_BCLK       in   1   clock
//  i_rst_n          in   1   async reset, active-low
//  i_valid          in   1   one-cycle pulse, new sample on i_data
//  i_data           in   16  signed sample from delay stage
//  i_state          in   3   top FSM state: 3=record, 4=play loop, other=pass-through
//  i_level          in   3   loop playback gain, (i_level+1)/8
//  i_sram_rdata     in   16  SRAM read data
//  o_sram_addr      out  20  SRAM address
//  o_sram_we_n      out  1   SRAM write enable, active-low
//  o_sram_wdata     out  16  SRAM write data
//  o_record_finish  out  1   one-cycle pulse when recording hits MAX_LEN
//  o_data           out  16  signed DAC sample
//  o_valid          out  1   one-cycle pulse, o_data updated
// BEHAVIOUR
//  Reset: all outputs 0 except o_sram_we_n=1. Pointers, loop_len and mode are cleared; FSM goes to S_IDLE.
//  FSM: S_IDLE -(i_valid)-> S_READ -> S_LATCH -> S_WRITE -> S_DONE -> S_IDLE.
//   Fixed latency: o_valid is asserted 4 cycles after i_valid in every mode.
//  On i_valid: latch i_data, i_state and i_level. Mode is fixed for that sample.
//  S_READ: addr=LOOP_BASE+play_ptr, we_n=1. Only in play mode with loop_len!=0; otherwise addr=0, we_n=1.
//  S_LATCH: capture i_sram_rdata into loop_smp. If no read was done, loop_smp=0.
//  S_WRITE: record mode -> addr=LOOP_BASE+wr_ptr, we_n=0, wdata=sample. Otherwise we_n=1.
//  S_DONE: o_data=sat16(sample + (loop_smp*(level+1))>>>3); o_valid=1; pointers advance.
//  Record entry (latched mode 3 while previous mode !=3): wr_ptr=0, loop_len=0 before the write.
//  Record advance: wr_ptr++. When wr_ptr reaches MAX_LEN-1 after write: o_record_finish pulses in S_DONE
//   and further record writes are suppressed.
//  Record exit (mode leaves 3): loop_len=wr_ptr (or MAX_LEN if capped); play_ptr=0.
//  Play advance: play_ptr wraps to 0 when play_ptr==loop_len-1. loop_len==0 -> pure pass-through.
//  Pass-through: o_data=sample. Pointers hold; loop_len is retained for later play.
//  Arithmetic: product is 19 bits signed; sum is 18 bits; saturate to [-32768,32767].
//  i_valid outside S_IDLE is ignored (cannot occur at 32 BCLK/channel).
//  Reset mid-sample: aborts immediately; o_sram_we_n=1 the same instant.
// CONFIGURATION
//  LOOP_OVERDUB_EN defined: in play mode S_WRITE writes back sat16(loop_smp + (sample>>>1))
//   to LOOP_BASE+play_ptr, layering live input onto the loop.
//  LOOP_OVERDUB_EN undefined: play mode never writes SRAM; the loop is read-only after recording.
// STRUCTURE
//  loop_pkg: state enum {S_IDLE,S_READ,S_LATCH,S_WRITE,S_DONE}, mode enum {M_PASS,M_REC,M_PLAY},
//   mode codes 3/4, LOOP_BASE default, sat16 function.
//  Sub-module loop_mix_sat: the gain multiply plus saturating add (shared by mix and overdub paths).
// TESTING
//  1 Pass-through: i_state=1, i_data=16'h1234 -> o_data=16'h1234 and o_valid 4 cycles after i_valid;
//    o_sram_we_n stays 1 throughout.
//  2 Record 5 samples {100..104}, then i_state=4 -> writes at 80000..80004, loop_len=5.
//  3 Play, level=7, i_data=0 -> o_data sequence 100,101,102,103,104,100 (wrap).
//  4 Saturation: loop 32000, input 32000, level=7 -> o_data=32767; loop -32000 with input -32000 -> -32768.
//  5 MAX_LEN=8 override, record 10 samples -> o_record_finish pulses once after the 8th sample;
//    samples 9-10 are not written.
//  6 Reset asserted in S_WRITE -> o_sram_we_n=1 and o_valid=0 at once; the next sample after release
//    passes through with loop_len=0.
//    With LOOP_OVERDUB_EN: play loop 100, input 40 -> 80000 rewritten to 120.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared types and helpers for the single-track looper stage.
// Optional feature macro: LOOP_OVERDUB_EN (layer live input onto the loop in play mode).
package loop_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_PASS,
        M_REC,
        M_PLAY
    } mode_t;

    localparam logic [2:0]  CODE_REC      = 3'd3;
    localparam logic [2:0]  CODE_PLAY     = 3'd4;
    localparam logic [19:0] LOOP_BASE_DEF = 20'h80000;
    localparam logic [19:0] MAX_LEN_DEF   = 20'h7FFFF;

    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'h7FFF;
        else if (v < -18'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    function automatic mode_t decode_mode(input logic [2:0] code);
        if (code == CODE_REC)
            return M_REC;
        else if (code == CODE_PLAY)
            return M_PLAY;
        else
            return M_PASS;
    endfunction

endpackage

// File: rtl/loop_mix_sat.sv
// Gain-scaled saturating add: y = sat16(a + (b * gain) >>> 3).
// Shared by the playback mix and the overdub write-back (LOOP_OVERDUB_EN).
module loop_mix_sat
    import loop_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [3:0]  gain_i,
    output logic [15:0] y_o
);

    logic signed [18:0] prod;
    logic signed [17:0] scaled;
    logic signed [17:0] sum;

    // gain is 1..8, so the product always fits 19 bits signed
    assign prod   = $signed({{3{b_i[15]}}, b_i}) * $signed({15'd0, gain_i});
    assign scaled = 18'(prod >>> 3);
    assign sum    = $signed({{2{a_i[15]}}, a_i}) + scaled;
    assign y_o    = sat16(sum);

endmodule

// File: rtl/loop_station.sv
// Single-track looper: records to the SRAM loop region, plays back mixed with live input.
// Define LOOP_OVERDUB_EN to write sat16(loop + live/2) back to the loop during play.
module loop_station
    import loop_pkg::*;
#(
    parameter logic [19:0] LOOP_BASE = LOOP_BASE_DEF,
    parameter logic [19:0] MAX_LEN   = MAX_LEN_DEF
) (
    input  logic        i_AUD_BCLK,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    input  logic [2:0]  i_state,
    input  logic [2:0]  i_level,
    input  logic [15:0] i_sram_rdata,
    output logic [19:0] o_sram_addr,
    output logic        o_sram_we_n,
    output logic [15:0] o_sram_wdata,
    output logic        o_record_finish,
    output logic [15:0] o_data,
    output logic        o_valid
);

    state_t      state_q, state_d;
    mode_t       mode_q, mode_in;
    logic [15:0] sample_q;
    logic [2:0]  level_q;
    logic [15:0] loop_smp_q;
    logic [15:0] o_data_q;
    logic [19:0] wr_ptr_q;
    logic [19:0] play_ptr_q;
    logic [19:0] loop_len_q;
    logic        cap_q;

    logic        rd_en;
    logic        rec_wr;
    logic        rec_last;
    logic [3:0]  gain;
    logic [15:0] mix_out;
    logic [19:0] addr;
    logic        we_n;
    logic [15:0] wdata;

    assign mode_in  = decode_mode(i_state);
    assign rd_en    = (mode_q == M_PLAY) && (loop_len_q != '0);
    assign rec_wr   = (mode_q == M_REC) && !cap_q;
    assign rec_last = (wr_ptr_q == MAX_LEN - 20'd1);
    assign gain     = {1'b0, level_q} + 4'd1;

    loop_mix_sat u_mix (
        .a_i    (sample_q),
        .b_i    (loop_smp_q),
        .gain_i (gain),
        .y_o    (mix_out)
    );

`ifdef LOOP_OVERDUB_EN
    logic [15:0] od_out;

    // gain 4 turns (b*4)>>>3 into b>>>1
    loop_mix_sat u_od (
        .a_i    (loop_smp_q),
        .b_i    (sample_q),
        .gain_i (4'd4),
        .y_o    (od_out)
    );
`endif

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // SRAM port is decoded from state so reset releases it immediately
    always_comb begin
        state_d = state_q;
        addr    = '0;
        we_n    = 1'b1;
        wdata   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid)
                    state_d = S_READ;
            end
            S_READ: begin
                state_d = S_LATCH;
                if (rd_en)
                    addr = LOOP_BASE + play_ptr_q;
            end
            S_LATCH: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_DONE;
                if (rec_wr) begin
                    addr  = LOOP_BASE + wr_ptr_q;
                    we_n  = 1'b0;
                    wdata = sample_q;
                end
`ifdef LOOP_OVERDUB_EN
                else if (rd_en) begin
                    addr  = LOOP_BASE + play_ptr_q;
                    we_n  = 1'b0;
                    wdata = od_out;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sample_q   <= '0;
            level_q    <= '0;
            mode_q     <= M_PASS;
            loop_smp_q <= '0;
            o_data_q   <= '0;
            wr_ptr_q   <= '0;
            play_ptr_q <= '0;
            loop_len_q <= '0;
            cap_q      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_valid) begin
                sample_q <= i_data;
                level_q  <= i_level;
                mode_q   <= mode_in;
                if (mode_in == M_REC && mode_q != M_REC) begin
                    wr_ptr_q   <= '0;
                    loop_len_q <= '0;
                    cap_q      <= 1'b0;
                end else if (mode_in != M_REC && mode_q == M_REC) begin
                    loop_len_q <= cap_q ? MAX_LEN : wr_ptr_q;
                    play_ptr_q <= '0;
                end
            end
            if (state_q == S_LATCH)
                loop_smp_q <= rd_en ? i_sram_rdata : '0;
            if (state_q == S_WRITE)
                o_data_q <= mix_out;
            if (state_q == S_DONE) begin
                if (rec_wr) begin
                    if (rec_last)
                        cap_q <= 1'b1;
                    else
                        wr_ptr_q <= wr_ptr_q + 20'd1;
                end
                if (rd_en) begin
                    if (play_ptr_q == loop_len_q - 20'd1)
                        play_ptr_q <= '0;
                    else
                        play_ptr_q <= play_ptr_q + 20'd1;
                end
            end
        end
    end

    assign o_sram_addr     = addr;
    assign o_sram_we_n     = we_n;
    assign o_sram_wdata    = wdata;
    assign o_data          = o_data_q;
    assign o_valid         = (state_q == S_DONE);
    assign o_record_finish = (state_q == S_DONE) && rec_wr && rec_last;

endmodule

// File: tb/tb_loop_station.sv
// Scoreboarded bench for loop_station (MAX_LEN overridden to 8).
// Honours LOOP_OVERDUB_EN when the design is built with it.
module tb_loop_station;

    localparam logic [19:0] BASE = 20'h80000;
`ifdef LOOP_OVERDUB_EN
    localparam bit OD = 1'b1;
`else
    localparam bit OD = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        logic        f;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic [2:0]  i_state;
    logic [2:0]  i_level;
    logic [15:0] rdata;
    logic [19:0] addr;
    logic        we_n;
    logic [15:0] wdata;
    logic        fin;
    logic [15:0] o_data;
    logic        o_valid;

    int checks;
    int failures;
    int cyc;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [15:0] mem[logic [19:0]];

    loop_station #(
        .LOOP_BASE (BASE),
        .MAX_LEN   (20'd8)
    ) dut (
        .i_AUD_BCLK      (clk),
        .i_rst_n         (rst_n),
        .i_valid         (i_valid),
        .i_data          (i_data),
        .i_state         (i_state),
        .i_level         (i_level),
        .i_sram_rdata    (rdata),
        .o_sram_addr     (addr),
        .o_sram_we_n     (we_n),
        .o_sram_wdata    (wdata),
        .o_record_finish (fin),
        .o_data          (o_data),
        .o_valid         (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read SRAM
    always @(posedge clk) begin
        if (!we_n)
            mem[addr] = wdata;
        rdata <= mem.exists(addr) ? mem[addr] : 16'h0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(o_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("o_data", 32'(o_data), 32'(e.d));
                chk("o_record_finish", 32'(fin), 32'(e.f));
                chk("latency", 32'(cyc - e.cyc), 32'd4);
            end
        end else if (fin) begin
            chk("finish_without_valid", 32'(fin), 32'd0);
        end
    end

    always @(negedge clk) begin
        wr_t w;
        if (!we_n) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", 32'(addr), 32'(w.a));
                chk("wr_data", 32'(wdata), 32'(w.d));
            end
        end
    end

    function automatic int od_val(input int lp, input int d);
        int s;
        s = lp + (d >>> 1);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic drive(input int st, input int lvl, input int d,
                         input int ex, input bit f, input bit wr,
                         input int woff, input int wd);
        exp_t e;
        wr_t  w;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_state = 3'(st);
        i_level = 3'(lvl);
        i_data  = 16'(d);
        e.d   = 16'(ex);
        e.f   = f;
        e.cyc = cyc;
        exp_q.push_back(e);
        if (wr) begin
            w.a = BASE + 20'(woff);
            w.d = 16'(wd);
            wr_q.push_back(w);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send(input int st, input int lvl, input int d,
                        input int ex, input bit f, input bit wr,
                        input int woff, input int wd);
        drive(st, lvl, d, ex, f, wr, woff, wd);
        repeat (5) @(posedge clk);
    endtask

    task automatic rec(input int d, input int off, input bit f, input bit wr);
        send(3, 0, d, d, f, wr, off, d);
    endtask

    task automatic play(input int lvl, input int d, input int ex,
                        input int ptr, input int lp);
        send(4, lvl, d, ex, 1'b0, OD, ptr, od_val(lp, d));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        i_state  = '0;
        i_level  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_finish", 32'(fin), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // pass-through
        send(1, 0, 32'h1234, 32'h1234, 1'b0, 1'b0, 0, 0);

        // record 100..104, then play level 7 with silence, wrapping
        for (int i = 0; i < 5; i++)
            rec(100 + i, i, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            play(7, 0, 100 + (i % 5), i % 5, 100 + (i % 5));

        // gain: 101*4>>>3=50, 102*1>>>3=12
        play(3, 10, 60, 1, 101);
        play(0, 10, 22, 2, 102);

        // saturation and arithmetic shift of negative loop
        rec(32000, 0, 1'b0, 1'b1);
        play(7, 32000, 32767, 0, 32000);
        rec(-32000, 0, 1'b0, 1'b1);
        play(7, -32000, -32768, 0, -32000);
        rec(-3, 0, 1'b0, 1'b1);
        play(0, 0, -1, 0, -3);

        // MAX_LEN=8: finish on 8th sample, 9th and 10th not written
        for (int i = 0; i < 10; i++)
            rec(200 + i, i, i == 7, i < 8);
        for (int i = 0; i < 9; i++)
            play(7, 0, 200 + (i % 8), i % 8, 200 + (i % 8));

        // reset while the record write is on the bus
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_state = 3'd3;
        i_level = 3'd0;
        i_data  = 16'd555;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_we_n", 32'(we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(we_n), 32'd1);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // loop_len cleared: play mode is pure pass-through
        send(4, 7, 32'h0777, 32'h0777, 1'b0, 1'b0, 0, 0);

        // overdub layering: loop 100, input 40 -> rewritten to 120
        rec(100, 0, 1'b0, 1'b1);
        play(7, 40, 140, 0, 100);

        repeat (10) @(posedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
